// File: rtl/tom_addr_pkg.sv
// Shared definitions for the Tom blitter address-register load path:
// grant encodings, pointer selects and the default starvation limit.
package tom_addr_pkg;

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_GPU   = 2'd1,
    GNT_ADDQ1 = 2'd2,
    GNT_ADDQ2 = 2'd3
  } gnt_e;

  localparam logic SEL_A1 = 1'b0;
  localparam logic SEL_A2 = 1'b1;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/addrload_hold.sv
// One-deep GPU write holding buffer: captures a pointer write and keeps it
// on hold_data until the arbiter's GPU load cycle drains it.
module addrload_hold
  import tom_addr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic              gpu_wr,
  input  logic              gpu_sel,
  input  logic [DATA_W-1:0] gpu_wdata,
  input  logic              drain,
  output logic              hold_vld,
  output logic              hold_sel,
  output logic [DATA_W-1:0] hold_data,
  output logic              wr_drop
);

  logic accept;

  // A draining buffer is refilled at the same edge it empties, so a write
  // landing in the load cycle never stalls.
  assign accept  = gpu_wr && (!hold_vld || drain);
  assign wr_drop = gpu_wr && hold_vld && !drain;

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      hold_vld  <= 1'b0;
      hold_sel  <= SEL_A1;
      hold_data <= '0;
    end else if (accept) begin
      hold_vld  <= 1'b1;
      hold_sel  <= gpu_sel;
      hold_data <= gpu_wdata;
    end else if (drain) begin
      hold_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/addrload_ctl.sv
// Address-register load sequencer: arbitrates held GPU writes against ADDQ
// updates, one pointer load per cycle. Optional macro ADDRLOAD_OVERRUN_EN
// adds the sticky write-while-busy overrun flag.
module addrload_ctl
  import tom_addr_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        resetl,
  input  logic        gpu_wr,
  input  logic        gpu_sel,
  input  logic [31:0] gpu_wdata,
  output logic        gpu_busy,
  output logic [31:0] hold_data,
  input  logic [1:0]  addq_req,
  output logic [1:0]  addq_ack,
  output logic        addqsel,
  output logic        a1_ld,
  output logic        a2_ld,
  output logic        overrun,
  input  logic        overrun_clr
);

  localparam int              DATA_W     = 32;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic             hold_vld;
  logic             hold_sel;
  logic             wr_drop;
  logic             drain;
  logic             full_p0;
  gnt_e             gnt_p0;
  gnt_e             gnt_p1;
  logic [CNT_W-1:0] cnt_p0;
  logic [CNT_W-1:0] cnt_p1;
  logic             a1_p0;
  logic             a2_p0;
  logic [1:0]       ack_p0;
  logic             addqsel_p0;

  addrload_hold #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk       (clk),
    .resetl    (resetl),
    .gpu_wr    (gpu_wr),
    .gpu_sel   (gpu_sel),
    .gpu_wdata (gpu_wdata),
    .drain     (drain),
    .hold_vld  (hold_vld),
    .hold_sel  (hold_sel),
    .hold_data (hold_data),
    .wr_drop   (wr_drop)
  );

  assign gpu_busy = hold_vld;
  // The held write is being consumed this cycle; it no longer competes.
  assign drain    = (gnt_p1 == GNT_GPU);
  assign full_p0  = hold_vld && !drain;

  // ---- p0: decision from current state and sampled requests ----
  always_comb begin
    gnt_p0     = GNT_IDLE;
    cnt_p0     = cnt_p1;
    a1_p0      = 1'b0;
    a2_p0      = 1'b0;
    ack_p0     = 2'b00;
    addqsel_p0 = addqsel;

    if (full_p0 && (cnt_p1 == STARVE_LIM)) gnt_p0 = GNT_GPU;
    else if (addq_req[0])                  gnt_p0 = GNT_ADDQ1;
    else if (addq_req[1])                  gnt_p0 = GNT_ADDQ2;
    else if (full_p0)                      gnt_p0 = GNT_GPU;

    case (gnt_p0)
      GNT_GPU: begin
        addqsel_p0 = 1'b0;
        a1_p0      = (hold_sel == SEL_A1);
        a2_p0      = (hold_sel == SEL_A2);
        cnt_p0     = '0;
      end
      GNT_ADDQ1: begin
        addqsel_p0 = 1'b1;
        a1_p0      = 1'b1;
        ack_p0     = 2'b01;
        if (full_p0 && (cnt_p1 != STARVE_LIM)) cnt_p0 = cnt_p1 + CNT_W'(1);
      end
      GNT_ADDQ2: begin
        addqsel_p0 = 1'b1;
        a2_p0      = 1'b1;
        ack_p0     = 2'b10;
        if (full_p0 && (cnt_p1 != STARVE_LIM)) cnt_p0 = cnt_p1 + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // ---- p1: load cycle outputs ----
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      gnt_p1   <= GNT_IDLE;
      cnt_p1   <= '0;
      a1_ld    <= 1'b0;
      a2_ld    <= 1'b0;
      addq_ack <= 2'b00;
      addqsel  <= 1'b0;
    end else begin
      gnt_p1   <= gnt_p0;
      cnt_p1   <= cnt_p0;
      a1_ld    <= a1_p0;
      a2_ld    <= a2_p0;
      addq_ack <= ack_p0;
      addqsel  <= addqsel_p0;
    end
  end

`ifdef ADDRLOAD_OVERRUN_EN
  // A new offending write outranks a simultaneous clear.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl)          overrun <= 1'b0;
    else if (wr_drop)     overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end
`else
  logic unused_ovr;
  assign unused_ovr = overrun_clr ^ wr_drop;
  assign overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_addrload_ctl.sv
// Self-checking bench for addrload_ctl: directed scenarios with literal
// expectations plus randomized traffic against a cycle-level reference model.
module tb_addrload_ctl;

  localparam int STARVE_MAX = 4;
  localparam int L_IDLE = 0;
  localparam int L_GPU  = 1;
  localparam int L_A1   = 2;
  localparam int L_A2   = 3;

  logic        clk = 1'b0;
  logic        resetl = 1'b0;
  logic        gpu_wr = 1'b0;
  logic        gpu_sel = 1'b0;
  logic [31:0] gpu_wdata = '0;
  logic [1:0]  addq_req = 2'b00;
  logic        overrun_clr = 1'b0;
  logic        gpu_busy;
  logic [31:0] hold_data;
  logic [1:0]  addq_ack;
  logic        addqsel;
  logic        a1_ld;
  logic        a2_ld;
  logic        overrun;

  always #5 clk = ~clk;

  addrload_ctl #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (3)
  ) dut (
    .clk         (clk),
    .resetl      (resetl),
    .gpu_wr      (gpu_wr),
    .gpu_sel     (gpu_sel),
    .gpu_wdata   (gpu_wdata),
    .gpu_busy    (gpu_busy),
    .hold_data   (hold_data),
    .addq_req    (addq_req),
    .addq_ack    (addq_ack),
    .addqsel     (addqsel),
    .a1_ld       (a1_ld),
    .a2_ld       (a2_ld),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model state: the pending write, what is being loaded now,
  // how many times the pending write has lost, and expected outputs.
  bit          m_full;
  bit          m_sel;
  logic [31:0] m_data;
  int          m_load;
  int          m_losses;
  bit          m_ovr;
  bit          e_a1;
  bit          e_a2;
  logic [1:0]  e_ack;
  bit          e_addqsel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit draining;
    bit waiting;
    bit accept;
    int winner;
    if (!resetl) begin
      m_full = 0; m_sel = 0; m_data = '0; m_load = L_IDLE; m_losses = 0; m_ovr = 0;
      e_a1 = 0; e_a2 = 0; e_ack = 2'b00; e_addqsel = 0;
      return;
    end
    draining = (m_load == L_GPU);
    waiting  = m_full && !draining;
    if (waiting && m_losses >= STARVE_MAX) winner = L_GPU;
    else if (addq_req[0])                  winner = L_A1;
    else if (addq_req[1])                  winner = L_A2;
    else if (waiting)                      winner = L_GPU;
    else                                   winner = L_IDLE;
    e_a1 = 0; e_a2 = 0; e_ack = 2'b00;
    if (winner == L_GPU) begin
      e_addqsel = 0;
      e_a1 = !m_sel;
      e_a2 = m_sel;
      m_losses = 0;
    end else if (winner != L_IDLE) begin
      e_addqsel = 1;
      e_a1 = (winner == L_A1);
      e_a2 = (winner == L_A2);
      e_ack = {e_a2, e_a1};
      if (waiting) m_losses = (m_losses + 1 > STARVE_MAX) ? STARVE_MAX : m_losses + 1;
    end
    accept = gpu_wr && (!m_full || draining);
    if (accept) begin
      m_full = 1; m_sel = gpu_sel; m_data = gpu_wdata;
    end else if (draining) begin
      m_full = 0;
    end
`ifdef ADDRLOAD_OVERRUN_EN
    if (gpu_wr && !accept) m_ovr = 1;
    else if (overrun_clr)  m_ovr = 0;
`endif
    m_load = winner;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge resetl);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("m_busy", gpu_busy, 32'(m_full));
        chk("m_hold", hold_data, m_data);
        chk("m_a1", a1_ld, 32'(e_a1));
        chk("m_a2", a2_ld, 32'(e_a2));
        chk("m_ack", addq_ack, 32'(e_ack));
        chk("m_addqsel", addqsel, 32'(e_addqsel));
        chk("m_ovr", overrun, 32'(m_ovr));
        chk("ld_both", a1_ld & a2_ld, 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n);
    gpu_wr = 0; addq_req = 2'b00; overrun_clr = 0;
    repeat (n) cyc();
  endtask

  bit exp_ovr;
  int mode;

  initial begin
`ifdef ADDRLOAD_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    resetl = 1'b1;
    @(negedge clk);
    chk("rst_busy", gpu_busy, 0);
    chk("rst_hold", hold_data, 0);
    chk("rst_a1", a1_ld, 0);
    chk("rst_a2", a2_ld, 0);
    chk("rst_ack", addq_ack, 0);
    chk("rst_addqsel", addqsel, 0);
    chk("rst_ovr", overrun, 0);

    // Lone GPU write to A1
    cyc(); gpu_wr = 1; gpu_sel = 0; gpu_wdata = 32'hAAAA5555;
    @(negedge clk); chk("lone_busy_c0", gpu_busy, 0);
    cyc(); gpu_wr = 0;
    @(negedge clk); chk("lone_busy_c1", gpu_busy, 1); chk("lone_a1_c1", a1_ld, 0);
    cyc();
    @(negedge clk);
    chk("lone_a1_c2", a1_ld, 1); chk("lone_sel_c2", addqsel, 0);
    chk("lone_hold_c2", hold_data, 32'hAAAA5555); chk("lone_busy_c2", gpu_busy, 1);
    cyc();
    @(negedge clk); chk("lone_busy_c3", gpu_busy, 0); chk("lone_a1_c3", a1_ld, 0);
    quiet(2);

    // Back-to-back writes: second lands in the drain cycle of the first
    gpu_wr = 1; gpu_sel = 0; gpu_wdata = 32'h11112222;
    cyc(); gpu_wr = 0;
    cyc(); gpu_wr = 1; gpu_sel = 1; gpu_wdata = 32'h0F0F0F0F;
    @(negedge clk); chk("bb_a1", a1_ld, 1);
    cyc(); gpu_wr = 0;
    @(negedge clk);
    chk("bb_busy", gpu_busy, 1); chk("bb_hold", hold_data, 32'h0F0F0F0F);
    chk("bb_ovr", overrun, 0);
    cyc();
    @(negedge clk); chk("bb_a2", a2_ld, 1); chk("bb_sel", addqsel, 0); chk("bb_a1_off", a1_ld, 0);
    cyc();
    @(negedge clk); chk("bb_busy_end", gpu_busy, 0);
    quiet(2);

    // Starvation: A1 ADDQ held, GPU write to A2 waits STARVE_MAX losses
    gpu_wr = 1; gpu_sel = 1; gpu_wdata = 32'hCAFEF00D; addq_req = 2'b01;
    cyc(); gpu_wr = 0;
    @(negedge clk); chk("stv_busy_c0", gpu_busy, 1); chk("stv_ack_c0", addq_ack, 2'b01);
    for (int k = 1; k <= STARVE_MAX; k++) begin
      cyc();
      @(negedge clk); chk("stv_ack", addq_ack, 2'b01); chk("stv_a2_off", a2_ld, 0);
    end
    cyc();
    @(negedge clk);
    chk("stv_a2", a2_ld, 1); chk("stv_sel", addqsel, 0); chk("stv_ack_gap", addq_ack, 0);
    cyc();
    @(negedge clk); chk("stv_resume", addq_ack, 2'b01); chk("stv_busy_end", gpu_busy, 0);
    quiet(3);

    // ADDQ priority: A1 always beats A2
    addq_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk); chk("pri_ack1", addq_ack, 2'b01);
    end
    cyc(); addq_req = 2'b10;
    @(negedge clk); chk("pri_ack1_last", addq_ack, 2'b01);
    cyc();
    @(negedge clk); chk("pri_ack2", addq_ack, 2'b10); chk("pri_a2", a2_ld, 1); chk("pri_sel", addqsel, 1);
    quiet(2);

    // Reset while a write is held
    gpu_wr = 1; gpu_sel = 1; gpu_wdata = 32'h12345678;
    cyc(); gpu_wr = 0; resetl = 0;
    @(negedge clk); chk("rmh_busy", gpu_busy, 0); chk("rmh_hold", hold_data, 0);
    cyc(); resetl = 1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk); chk("rmh_a2", a2_ld, 0);
    end

    // Write while busy (overrun when enabled, silent drop otherwise)
    addq_req = 2'b01; gpu_wr = 1; gpu_sel = 0; gpu_wdata = 32'h55AA55AA;
    cyc(); gpu_sel = 1; gpu_wdata = 32'hDEADBEEF;
    cyc(); gpu_wr = 0;
    @(negedge clk); chk("ovr_set", overrun, 32'(exp_ovr)); chk("ovr_hold", hold_data, 32'h55AA55AA);
    cyc(); overrun_clr = 1;
    @(negedge clk); chk("ovr_sticky", overrun, 32'(exp_ovr));
    cyc(); overrun_clr = 0;
    @(negedge clk); chk("ovr_clr", overrun, 0);
    quiet(8);

    // Randomized traffic against the model
    mode = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if ((n % 40) == 0) mode = $urandom_range(0, 2);
      gpu_wr      = ($urandom_range(0, 2) == 0);
      gpu_sel     = 1'($urandom_range(0, 1));
      gpu_wdata   = $urandom();
      overrun_clr = ($urandom_range(0, 15) == 0);
      case (mode)
        0:       addq_req = 2'($urandom_range(0, 3));
        1:       addq_req = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01;
        default: addq_req = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
      endcase
      resetl = ($urandom_range(0, 599) != 0);
    end
    resetl = 1;
    quiet(6);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
